// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller and the stages it steers.
// State codes are 3-bit; interrupt phase codes are shared with ID/EX.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MEM_HI    = 3'd1,
    ST_INT_DRAIN = 3'd2,
    ST_INT_PC_HI = 3'd3,
    ST_INT_PC_LO = 3'd4,
    ST_INT_FLAGS = 3'd5,
    ST_INT_VEC   = 3'd6
  } hz_state_e;

  localparam logic [1:0] INT_PHASE_NONE  = 2'd0;
  localparam logic [1:0] INT_PHASE_PC_HI = 2'd1;
  localparam logic [1:0] INT_PHASE_PC_LO = 2'd2;
  localparam logic [1:0] INT_PHASE_FLAGS = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the ID instruction reads the register that
// the load currently in EX has not yet produced.
module load_use_detect #(
  parameter int REG_W = 3
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_Rdst1,
  input  logic [REG_W-1:0] id_Rsrc,
  input  logic [REG_W-1:0] id_Rdst,
  input  logic             id_use_src,
  input  logic             id_use_dst,
  output logic             lu
);

  logic src_hit;
  logic dst_hit;

  assign src_hit = id_use_src & (id_Rsrc == ex_Rdst1);
  assign dst_hit = id_use_dst & (id_Rdst == ex_Rdst1);
  assign lu      = ex_mem_read & (src_hit | dst_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for IF_ID, ID_EX and EX_MEM: load-use bubbles,
// two-cycle 32-bit memory accesses and interrupt entry sequencing.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W     = 3,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_Rsrc,
  input  logic [REG_W-1:0] id_Rdst,
  input  logic             id_use_src,
  input  logic             id_use_dst,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_Rdst1,
  input  logic             ex_jmp_taken,
  input  logic             mem_acc32,
  input  logic             int_req,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       int_phase,
  output logic             int_ack
);

  localparam logic [2:0] CNT_MAX = 3'(DRAIN_CYC - 1);

  hz_state_e  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lu;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_lu (
    .ex_mem_read(ex_mem_read),
    .ex_Rdst1   (ex_Rdst1),
    .id_Rsrc    (id_Rsrc),
    .id_Rdst    (id_Rdst),
    .id_use_src (id_use_src),
    .id_use_dst (id_use_dst),
    .lu         (lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    int_phase    = INT_PHASE_NONE;
    int_ack      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (ex_jmp_taken) begin
          if (mem_acc32) state_d = ST_MEM_HI;
        end else if (mem_acc32) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          stall_ex_mem = 1'b1;
          state_d      = ST_MEM_HI;
        end else if (int_req) begin
          state_d = ST_INT_DRAIN;
          cnt_d   = '0;
        end else if (lu) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      ST_MEM_HI: state_d = ST_RUN;
      ST_INT_DRAIN: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        if (cnt_q >= CNT_MAX) state_d = ST_INT_PC_HI;
        else                  cnt_d   = cnt_q + 3'd1;
      end
      ST_INT_PC_HI: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        int_phase   = INT_PHASE_PC_HI;
        state_d     = ST_INT_PC_LO;
      end
      ST_INT_PC_LO: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        int_phase   = INT_PHASE_PC_LO;
        state_d     = ST_INT_FLAGS;
      end
      ST_INT_FLAGS: begin
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
        int_phase   = INT_PHASE_FLAGS;
        state_d     = ST_INT_VEC;
      end
      ST_INT_VEC: begin
        flush_if_id = 1'b1;
        int_ack     = 1'b1;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // a taken jump squashes the two younger stages in every state
    if (ex_jmp_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end

    if (reset) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      int_phase    = INT_PHASE_NONE;
      int_ack      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a sequence-position model
// checked every negedge, plus hand-computed literal checkpoints.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 3;
  localparam int D     = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_Rsrc, id_Rdst, ex_Rdst1;
  logic             id_use_src, id_use_dst, ex_mem_read;
  logic             ex_jmp_taken, mem_acc32, int_req;
  logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic             flush_if_id, flush_id_ex, int_ack;
  logic [1:0]       int_phase;
  logic [8:0]       outs;

  int vec  = 0;
  int miss = 0;
  // 0 RUN, -1 second half of 32-bit access, 1..D drain,
  // D+1..D+3 pushes, D+4 vector fetch
  int pos  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W    (REG_W),
    .DRAIN_CYC(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_Rsrc     (id_Rsrc),
    .id_Rdst     (id_Rdst),
    .id_use_src  (id_use_src),
    .id_use_dst  (id_use_dst),
    .ex_mem_read (ex_mem_read),
    .ex_Rdst1    (ex_Rdst1),
    .ex_jmp_taken(ex_jmp_taken),
    .mem_acc32   (mem_acc32),
    .int_req     (int_req),
    .stall_pc    (stall_pc),
    .stall_if_id (stall_if_id),
    .stall_id_ex (stall_id_ex),
    .stall_ex_mem(stall_ex_mem),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .int_phase   (int_phase),
    .int_ack     (int_ack)
  );

  assign outs = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                 flush_if_id, flush_id_ex, int_phase, int_ack};

  function automatic logic [8:0] model_out();
    logic [8:0] e;
    logic       hz;
    e  = '0;
    hz = ex_mem_read &&
         ((id_use_src && id_Rsrc == ex_Rdst1) ||
          (id_use_dst && id_Rdst == ex_Rdst1));
    if (reset) return '0;
    if (pos == 0) begin
      if (ex_jmp_taken)   e[4:3] = 2'b11;
      else if (mem_acc32) e[8:5] = 4'b1111;
      else if (int_req)   e = '0;
      else if (hz)        e = 9'b1100_01_00_0;
    end else if (pos > 0) begin
      e[8] = (pos != D + 4);
      e[4] = 1'b1;
      if (pos > D) e[2:1] = 2'((pos - D) % 4);
      e[0] = (pos == D + 4);
      if (ex_jmp_taken) e[3] = 1'b1;
    end else if (ex_jmp_taken) begin
      e[4:3] = 2'b11;
    end
    return e;
  endfunction

  function automatic int next_pos();
    if (pos == 0) begin
      if (mem_acc32) return -1;
      if (int_req && !ex_jmp_taken) return 1;
      return 0;
    end
    if (pos < 0 || pos == D + 4) return 0;
    return pos + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) pos <= 0;
    else       pos <= next_pos();
  end

  always @(negedge clk) begin
    logic [8:0] e;
    e = model_out();
    vec++;
    if (outs !== e) begin
      miss++;
      $display("FAIL model t=%0t pos=%0d got=%b exp=%b",
               $time, pos, outs, e);
    end
  end

  task automatic chk_now(input string nm, input logic [8:0] e);
    vec++;
    if (outs !== e) begin
      miss++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, outs, e);
    end
  endtask

  task automatic cyc(input string nm, input logic [8:0] e);
    @(negedge clk);
    chk_now(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    id_Rsrc      = '0;
    id_Rdst      = '0;
    ex_Rdst1     = '0;
    id_use_src   = 1'b0;
    id_use_dst   = 1'b0;
    ex_mem_read  = 1'b0;
    ex_jmp_taken = 1'b0;
    mem_acc32    = 1'b0;
    int_req      = 1'b0;
  endtask

  task automatic set_lu(input logic [2:0] s, input logic [2:0] d,
                        input logic us, input logic ud,
                        input logic rd, input logic [2:0] x);
    id_Rsrc     = s;
    id_Rdst     = d;
    id_use_src  = us;
    id_use_dst  = ud;
    ex_mem_read = rd;
    ex_Rdst1    = x;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset        = 1'b1;
    ex_jmp_taken = 1'b1;
    mem_acc32    = 1'b1;
    set_lu(3, 0, 1, 0, 1, 3);
    #1;
    chk_now("rst_init", 9'b0);
    run(2);
    clr();
    reset = 1'b0;

    set_lu(3, 0, 1, 0, 1, 3);
    cyc("lu_src", 9'b1100_01_00_0);
    clr();
    cyc("lu_gone", 9'b0);
    set_lu(0, 5, 0, 1, 1, 5);
    cyc("lu_dst", 9'b1100_01_00_0);
    set_lu(5, 0, 0, 0, 1, 5);
    cyc("lu_nouse", 9'b0);
    set_lu(2, 4, 1, 1, 1, 6);
    cyc("lu_nomatch", 9'b0);
    set_lu(6, 6, 1, 1, 0, 6);
    cyc("lu_noload", 9'b0);

    set_lu(3, 0, 1, 0, 1, 3);
    ex_jmp_taken = 1'b1;
    cyc("lu_jmp", 9'b0000_11_00_0);
    clr();

    mem_acc32 = 1'b1;
    cyc("acc32", 9'b1111_00_00_0);
    clr();
    set_lu(3, 0, 1, 0, 1, 3);
    cyc("mem_hi", 9'b0);
    clr();
    cyc("acc_run", 9'b0);

    mem_acc32    = 1'b1;
    ex_jmp_taken = 1'b1;
    cyc("jmp_acc32", 9'b0000_11_00_0);
    clr();
    set_lu(1, 0, 1, 0, 1, 1);
    cyc("jmp_mem_hi", 9'b0);
    clr();

    int_req = 1'b1;
    cyc("int_req", 9'b0);
    int_req = 1'b0;
    cyc("drain0", 9'b1000_10_00_0);
    ex_jmp_taken = 1'b1;
    cyc("drain1_jmp", 9'b1000_11_00_0);
    ex_jmp_taken = 1'b0;
    cyc("drain2", 9'b1000_10_00_0);
    cyc("pc_hi", 9'b1000_10_01_0);
    cyc("pc_lo", 9'b1000_10_10_0);
    cyc("flags", 9'b1000_10_11_0);
    cyc("vec_ack", 9'b0000_10_00_1);
    cyc("int_done", 9'b0);

    int_req   = 1'b1;
    mem_acc32 = 1'b1;
    cyc("int_acc32", 9'b1111_00_00_0);
    mem_acc32 = 1'b0;
    cyc("int_mem_hi", 9'b0);
    cyc("int_enter", 9'b0);
    int_req = 1'b0;
    cyc("int_drain0", 9'b1000_10_00_0);
    run(8);

    int_req = 1'b1;
    cyc("r_int_req", 9'b0);
    int_req = 1'b0;
    run(D + 1);
    @(negedge clk);
    chk_now("r_pc_lo", 9'b1000_10_10_0);
    #2;
    reset        = 1'b1;
    ex_jmp_taken = 1'b1;
    #1;
    chk_now("rst_async", 9'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_now("rst_hold", 9'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    for (int i = 0; i < 6; i++) cyc("post_rst", 9'b0);

    set_lu(7, 0, 1, 0, 1, 7);
    cyc("lu_after_rst", 9'b1100_01_00_0);
    clr();
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
